// File: rtl/memory_pkg.sv
// Shared constants and helpers for the team's memory blocks: read-during-write
// mode encodings, default byte count, byte-mask merge and per-byte even parity.
package memory_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BYTES              = DEFAULT_DATA_WIDTH / 8;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;
    typedef logic [BYTES-1:0]              byte_mask_t;

    function automatic word_t byte_merge(input word_t new_word, input word_t old_word,
                                         input byte_mask_t mask);
        word_t result;
        result = old_word;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (mask[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    // Stored bit that makes the byte plus parity bit hold an even number of ones.
    function automatic logic even_parity(input logic [7:0] data_byte);
        return ^data_byte;
    endfunction

endpackage

// File: rtl/ram_byte_merge.sv
// Combinational byte-mask merge: enabled bytes from new_word, others from old_word.
module ram_byte_merge
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]   new_word,
    input  logic [DATA_WIDTH-1:0]   old_word,
    input  logic [DATA_WIDTH/8-1:0] byte_enable,
    output logic [DATA_WIDTH-1:0]   merged_word
);

    always_comb begin
        merged_word = old_word;
        for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
            if (byte_enable[i]) begin
                merged_word[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dual_port_ram_be.sv
// Single-clock 1W/1R RAM with byte enables, sticky range-error flags and a
// selectable read-during-write mode. Define DUAL_PORT_RAM_PARITY_EN for per-byte parity.
module dual_port_ram_be
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int READ_MODE  = READ_FIRST
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic                    write_enable,
    input  logic [DATA_WIDTH/8-1:0] byte_enable,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    input  logic                    read_enable,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    output logic                    collision,
    input  logic                    error_clear,
    output logic                    error_write_addr,
    output logic                    error_read_addr
`ifdef DUAL_PORT_RAM_PARITY_EN
    ,
    output logic                    parity_error
`endif
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_in_range, rd_in_range;
    logic                  wr_ok, rd_ok, same_addr;
    logic                  wr_err, rd_err;
    logic [DATA_WIDTH-1:0] wr_old_word, wr_merged, rd_word;

    assign wr_in_range = ({1'b0, write_addr} < DEPTH_LIM);
    assign rd_in_range = ({1'b0, read_addr} < DEPTH_LIM);
    assign wr_ok       = write_enable && wr_in_range;
    assign rd_ok       = read_enable && rd_in_range;
    assign wr_err      = write_enable && !wr_in_range;
    assign rd_err      = read_enable && !rd_in_range;
    assign same_addr   = wr_ok && rd_ok && (write_addr == read_addr);
    assign wr_old_word = mem[write_addr];

    // On a same-address hit the write's old word is also the read's old word,
    // so one merge instance serves both the write path and the bypass.
    ram_byte_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_merge (
        .new_word    (write_data),
        .old_word    (wr_old_word),
        .byte_enable (byte_enable),
        .merged_word (wr_merged)
    );

    always_comb begin
        rd_word = mem[read_addr];
        if (READ_MODE == WRITE_FIRST && same_addr) begin
            rd_word = wr_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[write_addr] <= wr_merged;
        end
    end

`ifdef DUAL_PORT_RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] wr_par, rd_par;
    logic          par_bad;

    always_comb begin
        wr_par = par_mem[write_addr];
        for (int unsigned i = 0; i < NB; i++) begin
            if (byte_enable[i]) begin
                wr_par[i] = even_parity(write_data[8*i +: 8]);
            end
        end
    end

    always_comb begin
        rd_par = par_mem[read_addr];
        if (READ_MODE == WRITE_FIRST && same_addr) begin
            rd_par = wr_par;
        end
        par_bad = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            par_bad = par_bad | (even_parity(rd_word[8*i +: 8]) ^ rd_par[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            par_mem[write_addr] <= wr_par;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_error <= 1'b0;
        end else begin
            parity_error <= rd_ok && par_bad;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            read_data        <= '0;
            read_valid       <= 1'b0;
            collision        <= 1'b0;
            error_write_addr <= 1'b0;
            error_read_addr  <= 1'b0;
        end else begin
            if (rd_ok) begin
                read_data <= rd_word;
            end
            read_valid       <= rd_ok;
            collision        <= same_addr;
            // A new error in the clearing cycle keeps the flag set.
            error_write_addr <= wr_err || (error_write_addr && !error_clear);
            error_read_addr  <= rd_err || (error_read_addr && !error_clear);
        end
    end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench: two DEPTH=12 instances (READ_FIRST and WRITE_FIRST) share stimulus.
module tb_dual_port_ram_be;
    import memory_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] write_data;
    logic [3:0]  write_addr;
    logic        write_enable;
    logic [3:0]  byte_enable;
    logic [3:0]  read_addr;
    logic        read_enable;
    logic        error_clear;

    logic [31:0] rd0, rd1;
    logic        rv0, rv1, col0, col1, ew0, ew1, er0, er1;
`ifdef DUAL_PORT_RAM_PARITY_EN
    logic        pe0, pe1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dual_port_ram_be #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (4),
        .DEPTH      (12),
        .READ_MODE  (READ_FIRST)
    ) dut0 (
        .clk              (clk),
        .reset            (reset),
        .write_data       (write_data),
        .write_addr       (write_addr),
        .write_enable     (write_enable),
        .byte_enable      (byte_enable),
        .read_addr        (read_addr),
        .read_enable      (read_enable),
        .read_data        (rd0),
        .read_valid       (rv0),
        .collision        (col0),
        .error_clear      (error_clear),
        .error_write_addr (ew0),
        .error_read_addr  (er0)
`ifdef DUAL_PORT_RAM_PARITY_EN
        ,
        .parity_error     (pe0)
`endif
    );

    dual_port_ram_be #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (4),
        .DEPTH      (12),
        .READ_MODE  (WRITE_FIRST)
    ) dut1 (
        .clk              (clk),
        .reset            (reset),
        .write_data       (write_data),
        .write_addr       (write_addr),
        .write_enable     (write_enable),
        .byte_enable      (byte_enable),
        .read_addr        (read_addr),
        .read_enable      (read_enable),
        .read_data        (rd1),
        .read_valid       (rv1),
        .collision        (col1),
        .error_clear      (error_clear),
        .error_write_addr (ew1),
        .error_read_addr  (er1)
`ifdef DUAL_PORT_RAM_PARITY_EN
        ,
        .parity_error     (pe1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        error_clear  = 1'b0;
        byte_enable  = 4'hF;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        idle();
        write_enable = 1'b1;
        write_addr   = addr;
        write_data   = data;
        byte_enable  = be;
        tick();
        idle();
    endtask

    task automatic do_read(input logic [3:0] addr);
        idle();
        read_enable = 1'b1;
        read_addr   = addr;
        tick();
        idle();
    endtask

    initial begin
        reset = 1'b1;
        write_data = '0;
        write_addr = '0;
        read_addr  = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        check("reset_rd",   rd0, 32'h0);
        check("reset_rv",   {31'b0, rv0}, 32'h0);
        check("reset_col",  {31'b0, col1}, 32'h0);
        check("reset_errs", {28'b0, ew0, er0, ew1, er1}, 32'h0);

        // Full-word write and single-cycle valid pulse
        do_write(4'd3, 32'hDEADBEEF, 4'hF);
        do_read(4'd3);
        check("rd3_data",  rd0, 32'hDEADBEEF);
        check("rd3_valid", {31'b0, rv0}, 32'h1);
        tick();
        check("rd3_valid_drop", {31'b0, rv0}, 32'h0);
        check("rd3_hold",       rd0, 32'hDEADBEEF);

        // Partial byte write
        do_write(4'd5, 32'h11223344, 4'hF);
        do_write(4'd5, 32'hAABBCCDD, 4'b0101);
        do_read(4'd5);
        check("be_merge", rd0, 32'h11BB33DD);

        // All-zero byte enable is a silent no-op
        do_write(4'd5, 32'hFFFFFFFF, 4'h0);
        do_read(4'd5);
        check("be_zero_data", rd0, 32'h11BB33DD);
        check("be_zero_err",  {31'b0, ew0}, 32'h0);

        // Same-address read during write
        do_write(4'd7, 32'h0, 4'hF);
        idle();
        write_enable = 1'b1; write_addr = 4'd7; write_data = 32'hCAFEF00D; byte_enable = 4'hF;
        read_enable  = 1'b1; read_addr  = 4'd7;
        tick();
        idle();
        check("coll_read_first",  rd0, 32'h00000000);
        check("coll_write_first", rd1, 32'hCAFEF00D);
        check("coll_flag0", {31'b0, col0}, 32'h1);
        check("coll_flag1", {31'b0, col1}, 32'h1);
        tick();
        check("coll_drop", {30'b0, col0, col1}, 32'h0);
        do_read(4'd7);
        check("coll_stored", rd0, 32'hCAFEF00D);

        // Partial-byte WRITE_FIRST merge with old memory
        idle();
        write_enable = 1'b1; write_addr = 4'd7; write_data = 32'h12345678; byte_enable = 4'b1001;
        read_enable  = 1'b1; read_addr  = 4'd7;
        tick();
        idle();
        check("wf_merge", rd1, 32'h12FEF078);
        check("rf_old",   rd0, 32'hCAFEF00D);

        // Different addresses in the same cycle
        idle();
        write_enable = 1'b1; write_addr = 4'd8; write_data = 32'h0BADCAFE;
        read_enable  = 1'b1; read_addr  = 4'd3;
        tick();
        idle();
        check("indep_read", rd1, 32'hDEADBEEF);
        check("indep_col",  {31'b0, col1}, 32'h0);
        do_read(4'd8);
        check("indep_write", rd0, 32'h0BADCAFE);

        // Last legal address
        do_write(4'd11, 32'hA5A5A5A5, 4'hF);
        do_read(4'd11);
        check("top_addr",     rd0, 32'hA5A5A5A5);
        check("top_addr_err", {30'b0, ew0, er0}, 32'h0);

        // Out-of-range write and read
        do_write(4'd13, 32'hFFFFFFFF, 4'hF);
        check("oob_wr_flag", {30'b0, ew0, er0}, 32'h2);
        do_read(4'd12);
        check("oob_rd_valid", {31'b0, rv0}, 32'h0);
        check("oob_rd_hold",  rd0, 32'hA5A5A5A5);
        check("oob_rd_flag",  {30'b0, ew1, er1}, 32'h3);
        do_read(4'd5);
        check("oob_no_change", rd0, 32'h11BB33DD);
        check("sticky",        {30'b0, ew0, er0}, 32'h3);
        idle();
        error_clear = 1'b1;
        tick();
        idle();
        check("clear", {28'b0, ew0, er0, ew1, er1}, 32'h0);
        idle();
        error_clear = 1'b1; write_enable = 1'b1; write_addr = 4'd15; write_data = 32'h1;
        tick();
        idle();
        check("clear_vs_new", {30'b0, ew0, er0}, 32'h2);

        // Reset mid-stream ignores the presented write and read
        do_write(4'd2, 32'h5, 4'hF);
        do_read(4'd3);
        idle();
        reset = 1'b1;
        write_enable = 1'b1; write_addr = 4'd2; write_data = 32'hFFFFFFFF;
        read_enable  = 1'b1; read_addr  = 4'd2;
        tick();
        reset = 1'b0;
        idle();
        check("mid_reset_rd",   rd0, 32'h0);
        check("mid_reset_flgs", {26'b0, rv0, col0, ew0, er0, rv1, col1}, 32'h0);
        do_read(4'd2);
        check("mid_reset_mem", rd0, 32'h5);
        check("mid_reset_rv",  {31'b0, rv0}, 32'h1);

`ifdef DUAL_PORT_RAM_PARITY_EN
        begin
            logic [7:0] orig_byte;
            logic [7:0] bad_byte;
            logic       exp_err;
            do_write(4'd1, 32'h12345678, 4'hF);
            do_read(4'd1);
            check("par_clean", {30'b0, pe0, rv0}, 32'h1);
            orig_byte = dut0.mem[1][7:0];
            bad_byte  = orig_byte ^ 8'h01;
            dut0.mem[1][0] = ~dut0.mem[1][0];
            exp_err = even_parity(bad_byte) ^ even_parity(orig_byte);
            do_read(4'd1);
            check("par_err",   {31'b0, pe0}, {31'b0, exp_err});
            check("par_valid", {31'b0, rv0}, 32'h1);
            check("par_other", {31'b0, pe1}, 32'h0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
